// File: rtl/spike_event_encoder.sv
// Spike-event encoder: snapshots the spike vector on each timestep tick and
// serialises the set bits into {timestamp, index} FIFO words, lowest index first.
module spike_event_encoder #(
    parameter int N_NEURONS = 64,
    parameter int IDX_WIDTH = 6,
    parameter int TS_WIDTH  = 10,
    parameter int OVR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [N_NEURONS-1:0]          spikes,
    input  logic                          fifo_full,
    output logic                          wr,
    output logic [TS_WIDTH+IDX_WIDTH-1:0] data_out,
    output logic                          busy,
    output logic                          overrun,
    output logic [OVR_WIDTH-1:0]          ovr_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 next_s;
    logic [N_NEURONS-1:0]   snapshot_r;
    logic [N_NEURONS-1:0]   snap_clr_s;
    logic [TS_WIDTH-1:0]    ts_cnt_r;
    logic [TS_WIDTH-1:0]    ts_lat_r;
    logic                   overrun_r;
    logic [OVR_WIDTH-1:0]   ovr_count_r;
    logic [IDX_WIDTH-1:0]   idx_s;
    logic                   wr_s;
    logic                   ovr_tick_s;

    function automatic logic [IDX_WIDTH-1:0] lowest_set(input logic [N_NEURONS-1:0] v);
        logic [IDX_WIDTH-1:0] r;
        r = {IDX_WIDTH{1'b0}};
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_WIDTH'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Event selection, write strobe and overrun detection
    always_comb begin
        idx_s      = lowest_set(snapshot_r);
        // v & (v-1) drops exactly the lowest set bit, i.e. the one being written
        snap_clr_s = snapshot_r & (snapshot_r - N_NEURONS'(1));
        wr_s       = 1'b0;
        ovr_tick_s = 1'b0;
        if (state_r == ST_SCAN) begin
            wr_s       = (snapshot_r != {N_NEURONS{1'b0}}) && !fifo_full;
            ovr_tick_s = tick;
        end else begin
            wr_s       = 1'b0;
            ovr_tick_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tick && (spikes != {N_NEURONS{1'b0}})) begin
                    next_s = ST_SCAN;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (wr_s && (snap_clr_s == {N_NEURONS{1'b0}})) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_SCAN;
                end
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // State, snapshot, timestamp and overrun registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            snapshot_r  <= {N_NEURONS{1'b0}};
            ts_cnt_r    <= {TS_WIDTH{1'b0}};
            ts_lat_r    <= {TS_WIDTH{1'b0}};
            overrun_r   <= 1'b0;
            ovr_count_r <= {OVR_WIDTH{1'b0}};
        end else begin
            state_r <= next_s;
            if (tick) begin
                ts_cnt_r <= ts_cnt_r + {{(TS_WIDTH-1){1'b0}}, 1'b1};
            end
            if ((state_r == ST_IDLE) && tick) begin
                snapshot_r <= spikes;
                ts_lat_r   <= ts_cnt_r;
            end else if (wr_s) begin
                snapshot_r <= snap_clr_s;
            end
            if (ovr_tick_s) begin
                overrun_r <= 1'b1;
                if (ovr_count_r != {OVR_WIDTH{1'b1}}) begin
                    ovr_count_r <= ovr_count_r + {{(OVR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign wr        = wr_s;
    assign busy      = (state_r == ST_SCAN);
    assign data_out  = (state_r == ST_SCAN) ? {ts_lat_r, idx_s} : {(TS_WIDTH+IDX_WIDTH){1'b0}};
    assign overrun   = overrun_r;
    assign ovr_count = ovr_count_r;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Self-checking bench for spike_event_encoder: directed scenarios plus random
// traffic, compared cycle by cycle against a queue-based event model.
module tb_spike_event_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic [63:0] spikes = 64'h0;
    logic        fifo_full = 1'b0;
    logic        wr;
    logic [15:0] data_out;
    logic        busy;
    logic        overrun;
    logic [7:0]  ovr_count;

    int check_cnt = 0;
    int err_cnt   = 0;

    // Reference model: pending event words, timestamp counter, overrun state
    logic [15:0] mdl_q[$];
    logic [9:0]  mdl_ts = 10'd0;
    logic        mdl_ovr = 1'b0;
    int          mdl_ocnt = 0;
    bit          mdl_valid = 1'b0;

    spike_event_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .spikes    (spikes),
        .fifo_full (fifo_full),
        .wr        (wr),
        .data_out  (data_out),
        .busy      (busy),
        .overrun   (overrun),
        .ovr_count (ovr_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, advance the model
    task automatic step(input logic t, input logic [63:0] sp, input logic ff, input logic rs);
        bit mbusy;
        tick = t; spikes = sp; fifo_full = ff; reset = rs;
        @(negedge clk);
        mbusy = (mdl_q.size() != 0);
        if (mdl_valid) begin
            check_val("busy", {31'd0, busy}, {31'd0, mbusy});
            check_val("wr", {31'd0, wr}, {31'd0, mbusy && !ff});
            check_val("data_out", {16'd0, data_out}, mbusy ? {16'd0, mdl_q[0]} : 32'd0);
            check_val("overrun", {31'd0, overrun}, {31'd0, mdl_ovr});
            check_val("ovr_count", {24'd0, ovr_count}, mdl_ocnt);
        end
        if (rs) begin
            mdl_q.delete();
            mdl_ts = 10'd0;
            mdl_ovr = 1'b0;
            mdl_ocnt = 0;
            mdl_valid = 1'b1;
        end else begin
            if (mbusy && !ff) void'(mdl_q.pop_front());
            if (t) begin
                if (mbusy) begin
                    mdl_ovr = 1'b1;
                    if (mdl_ocnt < 255) mdl_ocnt++;
                end else begin
                    for (int i = 0; i < 64; i++)
                        if (sp[i]) mdl_q.push_back({mdl_ts, 6'(i)});
                end
                mdl_ts = mdl_ts + 10'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ff);
        for (int i = 0; i < n; i++) step(1'b0, 64'h0, ff, 1'b0);
    endtask

    initial begin
        logic [63:0] sp;
        step(1'b0, 64'h0, 1'b0, 1'b1);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Empty tick, then three-event tick at ts=1
        step(1'b1, 64'h0, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 64'h8000_0000_0000_0009, 1'b0, 1'b0);
        idle(6, 1'b0);

        // Stall for 5 cycles right after the tick
        step(1'b1, 64'hF, 1'b0, 1'b0);
        idle(5, 1'b1);
        idle(6, 1'b0);

        // Full vector with an overrun tick 10 cycles in
        step(1'b1, {64{1'b1}}, 1'b0, 1'b0);
        idle(9, 1'b0);
        step(1'b1, 64'h5, 1'b0, 1'b0);
        idle(60, 1'b0);
        step(1'b1, 64'h2, 1'b0, 1'b0);
        idle(4, 1'b0);

        // Timestamp wrap, then an event on index 5
        step(1'b0, 64'h0, 1'b0, 1'b1);
        for (int i = 0; i < 1024; i++) step(1'b1, 64'h0, 1'b0, 1'b0);
        step(1'b1, 64'h20, 1'b0, 1'b0);
        idle(3, 1'b0);

        // 300 overruns against a stalled scan saturate the counter
        step(1'b1, 64'h3, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 64'hFF, 1'b1, 1'b0);
        idle(4, 1'b0);

        // Reset after 3 of 8 events, then restart from ts 0
        step(1'b1, 64'hFF00, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        idle(2, 1'b0);
        step(1'b1, 64'h81, 1'b0, 1'b0);
        idle(4, 1'b0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(3))
                0: sp = {$urandom, $urandom};
                1: sp = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                2: sp = 64'h1 << $urandom_range(63);
                default: sp = 64'h0;
            endcase
            step(($urandom_range(29) == 0), sp, ($urandom_range(3) == 0),
                 ($urandom_range(799) == 0));
        end
        idle(100, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
